// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 responder: FSM states, instruction
// bit positions, blank code and DDRAM address/index mapping helpers.
package lcd_pkg;

    localparam logic [7:0] BLANK_CHAR  = 8'h20;
    localparam int         DDRAM_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_t;

    // Instructions are decoded by the position of their highest set bit.
    localparam int CMD_SET_DDRAM_BIT  = 7;
    localparam int CMD_SET_CGRAM_BIT  = 6;
    localparam int CMD_FUNC_SET_BIT   = 5;
    localparam int CMD_SHIFT_BIT      = 4;
    localparam int CMD_DISP_CTRL_BIT  = 3;
    localparam int CMD_ENTRY_MODE_BIT = 2;
    localparam int CMD_HOME_BIT       = 1;
    localparam int CMD_CLEAR_BIT      = 0;

    function automatic logic [4:0] addr_to_idx(input logic [6:0] a);
        logic unused_bits;
        unused_bits = ^a[5:4];
        return {a[6], a[3:0]};
    endfunction

    function automatic logic [6:0] idx_to_addr(input logic [4:0] i);
        return {i[4], 2'b00, i[3:0]};
    endfunction

    // Stepping in index space gives the 0x0F<->0x40 and 0x4F<->0x00 wraps for free.
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [4:0] i;
        i = addr_to_idx(a);
        i = inc ? i + 5'd1 : i - 5'd1;
        return idx_to_addr(i);
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display data RAM: one write port, two combinational read ports,
// every cell returns to the blank character on reset.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_idx_a,
    output logic [7:0] rd_data_a,
    input  logic [4:0] rd_idx_b,
    output logic [7:0] rd_data_b
);

    logic [7:0] cell_q [DDRAM_DEPTH];

    generate
        for (genvar gi = 0; gi < DDRAM_DEPTH; gi++) begin : g_cell
            logic [7:0] cell_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cell_reg <= BLANK_CHAR;
                end else if (we && wr_idx == 5'(gi)) begin
                    cell_reg <= wr_data;
                end
            end

            assign cell_q[gi] = cell_reg;
        end
    endgenerate

    assign rd_data_a = cell_q[rd_idx_a];
    assign rd_data_b = cell_q[rd_idx_b];

endmodule

// File: rtl/hd44780_responder.sv
// Behavioural HD44780 character-LCD controller seen from the bus side:
// decodes instructions, stores characters and models the busy flag.
module hd44780_responder
    import lcd_pkg::*;
#(
    parameter int CMD_BUSY = 40,
    parameter int CLR_BUSY = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       display_on,
    output logic [6:0] addr,
    output logic       wr_pulse,
    output logic [7:0] wr_char,
    output logic [4:0] wr_idx,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CMD_BUSY + CLR_BUSY + 1);
    localparam logic [CNT_W-1:0] CMD_LOAD      = CNT_W'(CMD_BUSY - 1);
    localparam logic [CNT_W-1:0] HOME_LOAD     = CNT_W'(CLR_BUSY - 1);
    // CLEAR already spends one cycle per DDRAM entry of the total Clear time.
    localparam logic [CNT_W-1:0] CLR_TAIL_LOAD = CNT_W'(CLR_BUSY - DDRAM_DEPTH - 1);

    lcd_state_t state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0] clr_idx_reg;
    logic       en_reg, rs_reg, rw_reg;
    logic [7:0] data_reg;
    logic [6:0] addr_reg;
    logic       id_reg, s_reg, dl_reg, n_reg;
    logic       display_on_reg, cursor_reg, blink_reg;
    logic       busy_reg, overrun_reg;
    logic       wr_pulse_reg;
    logic [7:0] wr_char_reg;
    logic [4:0] wr_idx_reg;

    logic       strobe, idle_write, ram_we;
    logic [4:0] cur_idx, ram_wr_idx;
    logic [7:0] ram_wr_data, cur_char;
    logic       unused_mode;

    assign strobe     = en_reg && !en;
    assign cur_idx    = addr_to_idx(addr_reg);
    assign idle_write = strobe && !rw_reg && (state_reg == ST_IDLE);

    assign ram_we      = (state_reg == ST_CLEAR) || (idle_write && rs_reg);
    assign ram_wr_idx  = (state_reg == ST_CLEAR) ? clr_idx_reg : cur_idx;
    assign ram_wr_data = (state_reg == ST_CLEAR) ? BLANK_CHAR : data_reg;

    lcd_ddram u_ddram (
        .clk       (clk),
        .reset     (reset),
        .we        (ram_we),
        .wr_idx    (ram_wr_idx),
        .wr_data   (ram_wr_data),
        .rd_idx_a  (cur_idx),
        .rd_data_a (cur_char),
        .rd_idx_b  (rd_idx),
        .rd_data_b (rd_char)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            clr_idx_reg    <= '0;
            en_reg         <= 1'b0;
            rs_reg         <= 1'b0;
            rw_reg         <= 1'b0;
            data_reg       <= 8'h00;
            addr_reg       <= 7'h00;
            id_reg         <= 1'b1;
            s_reg          <= 1'b0;
            dl_reg         <= 1'b1;
            n_reg          <= 1'b0;
            display_on_reg <= 1'b0;
            cursor_reg     <= 1'b0;
            blink_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            wr_pulse_reg   <= 1'b0;
            wr_char_reg    <= 8'h00;
            wr_idx_reg     <= 5'd0;
        end else begin
            wr_pulse_reg <= 1'b0;
            en_reg       <= en;
            if (en) begin
                rs_reg   <= rs;
                rw_reg   <= rw;
                data_reg <= data;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (idle_write) begin
                        busy_reg  <= 1'b1;
                        state_reg <= ST_BUSY;
                        cnt_reg   <= CMD_LOAD;
                        if (rs_reg) begin
                            wr_pulse_reg <= 1'b1;
                            wr_char_reg  <= data_reg;
                            wr_idx_reg   <= cur_idx;
                            addr_reg     <= step_addr(addr_reg, id_reg);
                        end else if (data_reg[CMD_SET_DDRAM_BIT]) begin
                            addr_reg <= data_reg[6:0];
                        end else if (data_reg[CMD_SET_CGRAM_BIT]) begin
                            // No CGRAM model; only the busy time applies.
                        end else if (data_reg[CMD_FUNC_SET_BIT]) begin
                            dl_reg <= data_reg[4];
                            n_reg  <= data_reg[3];
                        end else if (data_reg[CMD_SHIFT_BIT]) begin
                            if (!data_reg[3]) begin
                                addr_reg <= step_addr(addr_reg, data_reg[2]);
                            end
                        end else if (data_reg[CMD_DISP_CTRL_BIT]) begin
                            display_on_reg <= data_reg[2];
                            cursor_reg     <= data_reg[1];
                            blink_reg      <= data_reg[0];
                        end else if (data_reg[CMD_ENTRY_MODE_BIT]) begin
                            id_reg <= data_reg[1];
                            s_reg  <= data_reg[0];
                        end else if (data_reg[CMD_HOME_BIT]) begin
                            addr_reg <= 7'h00;
                            cnt_reg  <= HOME_LOAD;
                        end else if (data_reg[CMD_CLEAR_BIT]) begin
                            state_reg   <= ST_CLEAR;
                            clr_idx_reg <= 5'd0;
                        end
                    end else if (strobe && rw_reg && rs_reg) begin
                        addr_reg <= step_addr(addr_reg, id_reg);
                    end
                end

                ST_CLEAR: begin
                    if (strobe && !rw_reg) begin
                        overrun_reg <= 1'b1;
                    end
                    clr_idx_reg <= clr_idx_reg + 5'd1;
                    if (clr_idx_reg == 5'(DDRAM_DEPTH - 1)) begin
                        addr_reg  <= 7'h00;
                        id_reg    <= 1'b1;
                        state_reg <= ST_BUSY;
                        cnt_reg   <= CLR_TAIL_LOAD;
                    end
                end

                ST_BUSY: begin
                    if (strobe && !rw_reg) begin
                        overrun_reg <= 1'b1;
                    end
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Mode bits kept for completeness; nothing in this model consumes them.
    assign unused_mode = ^{s_reg, dl_reg, n_reg, cursor_reg, blink_reg};

    assign data_out   = (en && rw) ? (rs ? cur_char : {busy_reg, addr_reg}) : 8'h00;
    assign busy       = busy_reg;
    assign display_on = display_on_reg;
    assign addr       = addr_reg;
    assign wr_pulse   = wr_pulse_reg;
    assign wr_char    = wr_char_reg;
    assign wr_idx     = wr_idx_reg;
    assign overrun    = overrun_reg;

endmodule

// File: doc/hd44780_responder.md
HD44780_RESPONDER -- requirements
Module: hd44780_responder

Interface
REQ-001 SHALL have parameter CMD_BUSY, default 40, giving busy cycles after a normal command or data write.
REQ-002 SHALL have parameter CLR_BUSY, default 64 (must be >= 33), giving busy cycles after Clear or Return Home.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port rs, input, 1 bit: register select (0 = instruction, 1 = data).
REQ-006 SHALL have port rw, input, 1 bit: 0 = write, 1 = read.
REQ-007 SHALL have port en, input, 1 bit: enable strobe.
REQ-008 SHALL have port data, input, 8 bits: write bus from the driver.
REQ-009 SHALL have port data_out, output, 8 bits: read bus.
REQ-010 SHALL have port busy, output, 1 bit: busy flag.
REQ-011 SHALL have port display_on, output, 1 bit: Display Control D bit.
REQ-012 SHALL have port addr, output, 7 bits: DDRAM address counter.
REQ-013 SHALL have port wr_pulse, output, 1 bit, plus wr_char (8 bits) and wr_idx (5 bits): a one-cycle character-write report.
REQ-014 SHALL have port rd_idx, input, 5 bits, and rd_char, output, 8 bits: combinational scan-out of DDRAM.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when a write arrives while busy.

Function
REQ-016 SHALL register en each cycle and define a strobe when the registered en is 1 and the current en is 0; rs, rw and data are taken from the last cycle in which en was 1.
REQ-017 SHALL map addr to a 32-entry DDRAM as idx = {addr[6], addr[3:0]}, giving line 1 = 0x00-0x0F and line 2 = 0x40-0x4F.
REQ-018 SHALL, on a write strobe with rs=0 while not busy, decode by the highest set bit:
- 0x80+: addr=data[6:0]
- 0x40+: CGRAM, ignored
- 0x20+: store DL=data[4] and N=data[3]
- 0x10+: if data[3]=0, step addr ±1 per data[2]
- 0x08+: display_on=data[2], cursor=data[1], blink=data[0]
- 0x04+: ID=data[1], S=data[0] stored
- 0x02: addr=0
- 0x01: Clear
REQ-019 SHALL, on a write strobe with rs=1 while not busy, write DDRAM[idx]=data, pulse wr_pulse with wr_char=data and wr_idx=idx in the cycle after the strobe, then step addr per ID.
REQ-020 SHALL step addr with wrap: 0x0F+1 -> 0x40, 0x4F+1 -> 0x00, 0x00-1 -> 0x4F, 0x40-1 -> 0x0F; Set Address values outside the two line ranges are masked by the idx mapping.
REQ-021 SHALL use a state machine IDLE -> BUSY (counting CMD_BUSY) -> IDLE, and IDLE -> CLEAR -> BUSY for Clear.
REQ-022 SHALL, in CLEAR, write 0x20 to one DDRAM entry per cycle (idx 0..31), then set addr=0 and ID=1 and finish the CLR_BUSY count in BUSY.
REQ-023 SHALL hold busy=1 from the cycle after an accepted strobe until the count expires; busy is 0 in IDLE.
REQ-024 SHALL ignore a write strobe arriving while busy (no state, DDRAM or addr change) and set overrun.
REQ-025 SHALL, while en=1 and rw=1, drive data_out={busy, addr} if rs=0 and DDRAM[idx] if rs=1; otherwise data_out=0.
REQ-026 SHALL step addr per ID on the strobe of a data read (rs=1, rw=1) when not busy; reads never set busy.

Reset
REQ-027 SHALL, on reset, set:
- busy=0, display_on=0, cursor=0, blink=0
- addr=0, ID=1, S=0, DL=1, N=0
- wr_pulse=0, overrun=0, data_out=0
- all DDRAM=0x20, state=IDLE
Reset asserted mid-CLEAR or mid-BUSY aborts immediately.

Structure
REQ-028 SHALL place the command-decode constants, the state enum, the blank code 0x20 and the addr-to-idx function in shared package lcd_pkg.
REQ-029 SHALL implement DDRAM (32x8, one write port, two combinational read ports, async reset to 0x20) as sub-module lcd_ddram.

Verification
REQ-030 SHALL check reset: after release, busy=0, addr=0x00, rd_char=0x20 for every rd_idx.
REQ-031 SHALL check the init sequence: strobes 0x38, 0x0C, 0x01, 0x06, then "WASHING", each spaced 100 cycles -> display_on=1, DDRAM[0..6]=57 41 53 48 49 4E 47, addr=0x07, overrun=0.
REQ-032 SHALL check addr wrap: 0x8F then data 0x41 -> DDRAM[15]=0x41, addr=0x40; then data 0x42 -> DDRAM[16]=0x42.
REQ-033 SHALL check overrun: data 0x41 followed 5 cycles later by data 0x42 -> only 0x41 is written, overrun=1, addr advances by one.
REQ-034 SHALL check busy-flag read: en=1, rw=1, rs=0 during a Clear -> data_out[7]=1; after CLR_BUSY cycles -> data_out=0x00.
REQ-035 SHALL check reset mid-CLEAR: reset at CLEAR cycle 10 -> busy=0, state=IDLE, all DDRAM=0x20.
